mask_generation: RTL and testbench
==================================

Name: mask_generation

Overview:
- Per-clock generator of a one-row pixel-exposure mask, up to maxImageSensorCols columns wide, for a coded-exposure image sensor.
- A microprocessor loads a 32-bit pattern. The block then outputs either a sliding (rotating) pattern or a pseudo-random LFSR mask, one row per enabled clock.
- It sits between the processor register interface and the sensor column drivers.

Parameters:
- maxImageSensorCols, default 64: maximum mask width in columns. Legal values are multiples of 8, from 8 to 64 inclusive.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- clk_en, input, 1: clock enable. When low, all state holds.
- imageSensorResolution, input, 2: active width. 00 = maxImageSensorCols, 01 = /2, 10 = /4, 11 = /8.
- pattern_w, input, 5: sliding-pattern width in bits. 0 means 32.
- pattern, input, [0:31]: pattern bits. Bit 0 maps to column 0.
- right_sliding, input, 1: 1 = rotate toward higher column index; 0 = rotate toward lower index.
- load_pattern, input, 1: load or seed strobe.
- mask_type, input, 1: 0 = sliding pattern; 1 = random mask.
- mg_mask, output, [0:maxImageSensorCols-1]: registered mask row.
- rp_valid, output, 1: mg_mask is valid.

Behaviour:
- All state updates on the rising edge of clk, only when clk_en=1 or rst=1. rst has priority over clk_en.
- Reset: mg_mask = 0, internal 64-bit state = 0, rp_valid = 0.
- Active width W = maxImageSensorCols >> imageSensorResolution. Output columns with index >= W always read 0.
- Load, mask_type=0:
  - state cleared.
  - state[i] = pattern[i] for i < pattern_w (0 → 32), clipped to W.
- Load, mask_type=1:
  - state[0:31] = pattern; state[32:63] = ~pattern. The seed is therefore never all-zero.
  - mg_mask shows state[0:maxImageSensorCols-1].
- Load timing:
  - New mask appears on mg_mask the edge after load_pattern is sampled high. No shift occurs on a load cycle.
  - Holding load_pattern high reloads every cycle.
- Sliding mode, after load:
  - Each enabled cycle, rotate the active columns [0:W-1] by one.
  - right_sliding=1: col i → col (i+1) mod W.
  - right_sliding=0: col i → col (i-1) mod W.
  - Direction is sampled every cycle, so a change takes effect on the next shift.
- Random mode, after load:
  - Each enabled cycle, the 64-bit Fibonacci LFSR steps once.
  - next[0:62] = state[1:63]; next[63] = state[0]^state[1]^state[3]^state[4] (x^64+x^63+x^61+x^60+1).
  - mg_mask = state[0:maxImageSensorCols-1], masked to W.
- rp_valid:
  - Rises the edge after the first load and stays 1.
  - Cleared to 0 when mask_type changes value without a simultaneous load; it stays 0 until the next load.
  - The mask still updates while rp_valid=0.
- Resolution change mid-run:
  - Output masking applies immediately.
  - Rotation wraps at the new W.
  - Bits already held at columns >= W are zeroed on the next shift.
- Simultaneous load and mask_type change: the load wins and is interpreted using the new mask_type.
- clk_en=0: mask, state and rp_valid all hold. A load strobe is ignored.

Decomposition:
- Package mask_generation_pkg:
  - Enum mask_type_e {MT_SLIDING=1'b0, MT_RANDOM=1'b1}.
  - Enum resolution_e.
  - Constant LFSR_TAPS.
  - Constant PATTERN_BITS=32.
  - Function active_width(res, max).
- One natural sub-module: mask_lfsr64. It holds the 64-bit LFSR with seed load and step enable, and is instantiated by the top.
- Sliding rotation and output masking stay in the top module.

Test Plan (maxImageSensorCols=64, res=00 unless noted):
- Sliding right:
  - Stimulus: load pattern=0xF0000000, w=4, right_sliding=1, then run.
  - Edge after load: cols 0–3 = 1, rp_valid=1.
  - After 1 shift: cols 1–4.
  - After 60 shifts: cols 60–63.
  - After 61 shifts: cols 61, 62, 63, 0.
- Sliding left:
  - Stimulus: same load, right_sliding=0.
  - After 1 shift: cols 63, 0, 1, 2.
  - Flip to right_sliding=1 mid-run: the next shift reverses direction.
- Random:
  - Stimulus: load pattern=0xAAAAAAAA, mask_type=1.
  - First mask: 0xAAAAAAAA_55555555.
  - Next row: state shifted down by one with bit 63 = s0^s1^s3^s4.
  - 1000 cycles: mask is never all-zero.
- Resolution and enable:
  - res=01 with the sliding load: wrap occurs col 31 → col 0; cols 32–63 stay 0.
  - res=11: W=8.
  - clk_en=0 for 5 cycles: mg_mask frozen.
- Reset and mode switch:
  - rst mid-run: next edge gives mg_mask=0 and rp_valid=0.
  - Toggle mask_type without load: rp_valid=0 until the next load.

Source files
------------

// File: rtl/mask_generation_pkg.sv
// Shared types and helpers for the coded-exposure mask generator.
package mask_generation_pkg;

  typedef enum logic {
    MT_SLIDING = 1'b0,
    MT_RANDOM  = 1'b1
  } mask_type_e;

  typedef enum logic [1:0] {
    RES_FULL    = 2'b00,
    RES_HALF    = 2'b01,
    RES_QUARTER = 2'b10,
    RES_EIGHTH  = 2'b11
  } resolution_e;

  // Feedback taps of the 64-bit Fibonacci LFSR, state indexed [0:63]:
  // taps at positions 0, 1, 3 and 4 (x^64 + x^63 + x^61 + x^60 + 1).
  localparam logic [0:63] LFSR_TAPS = 64'hD800_0000_0000_0000;

  localparam int PATTERN_BITS = 32;

  // Number of active columns for a given resolution code.
  function automatic int active_width(input logic [1:0] res, input int max_cols);
    return max_cols >> res;
  endfunction

endpackage

// File: rtl/mask_lfsr64.sv
// 64-bit mask state register: either loaded with a full new value or
// stepped as a Fibonacci LFSR.
module mask_lfsr64
  import mask_generation_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [0:63] seed,
  output logic [0:63] state
);

  // Load has priority over a step; the feedback bit enters at index 63.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
    end else if (load) begin
      state <= seed;
    end else if (step) begin
      state <= {state[1:63], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/mask_generation.sv
// Per-clock exposure-mask row generator: sliding pattern or LFSR mask,
// restricted to the active sensor width.
module mask_generation
  import mask_generation_pkg::*;
#(
  parameter int maxImageSensorCols = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_en,
  input  logic [1:0]                    imageSensorResolution,
  input  logic [4:0]                    pattern_w,
  input  logic [0:31]                   pattern,
  input  logic                          right_sliding,
  input  logic                          load_pattern,
  input  logic                          mask_type,
  output logic [0:maxImageSensorCols-1] mg_mask,
  output logic                          rp_valid
);

  logic [0:63] state;
  logic [0:63] rot_val;
  logic [0:63] load_val;
  logic [0:63] seed;
  logic [5:0]  src;
  logic        lfsr_load;
  logic        lfsr_step;
  logic        prev_type;
  int          w;
  int          pw;

  assign w  = active_width(imageSensorResolution, maxImageSensorCols);
  assign pw = (pattern_w == 5'd0) ? PATTERN_BITS : int'(pattern_w);

  // One-column rotation of the active window; columns outside it drop to 0.
  always_comb begin
    rot_val = '0;
    src     = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < w) begin
        if (right_sliding) begin
          src = (i == 0) ? 6'(w - 1) : 6'(i - 1);
        end else begin
          src = (i == w - 1) ? 6'd0 : 6'(i + 1);
        end
        rot_val[i] = state[src];
      end
    end
  end

  // Value written on a load strobe, interpreted with the current mask_type.
  always_comb begin
    load_val = '0;
    if (mask_type == MT_RANDOM) begin
      load_val = {pattern, ~pattern};
    end else begin
      for (int i = 0; i < PATTERN_BITS; i++) begin
        if (i < pw && i < w) load_val[i] = pattern[i];
      end
    end
  end

  // Sliding mode rewrites the whole state each cycle; random mode steps it.
  assign lfsr_load = clk_en & (load_pattern | (mask_type == MT_SLIDING));
  assign lfsr_step = clk_en & ~load_pattern & (mask_type == MT_RANDOM);
  assign seed      = load_pattern ? load_val : rot_val;

  mask_lfsr64 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (seed),
    .state (state)
  );

  // Valid flag: set by a load, dropped when the mode changes without one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rp_valid  <= 1'b0;
      prev_type <= MT_SLIDING;
    end else if (clk_en) begin
      prev_type <= mask_type;
      if (load_pattern) begin
        rp_valid <= 1'b1;
      end else if (mask_type != prev_type) begin
        rp_valid <= 1'b0;
      end
    end
  end

  // Columns beyond the current active width always read zero.
  always_comb begin
    for (int i = 0; i < maxImageSensorCols; i++) begin
      mg_mask[i] = (i < w) ? state[i] : 1'b0;
    end
  end

endmodule

// File: tb/tb_mask_generation.sv
// Self-checking bench for mask_generation with a behavioural mask model.
module tb_mask_generation;

  localparam int COLS = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            clk_en;
  logic [1:0]      res;
  logic [4:0]      pattern_w;
  logic [0:31]     pattern;
  logic            right_sliding;
  logic            load_pattern;
  logic            mask_type;
  logic [0:COLS-1] mg_mask;
  logic            rp_valid;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit mdl[64];
  bit m_valid;
  bit m_prev;

  logic [0:63] saved;

  always #5 clk = ~clk;

  mask_generation #(.maxImageSensorCols(COLS)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .clk_en                (clk_en),
    .imageSensorResolution (res),
    .pattern_w             (pattern_w),
    .pattern               (pattern),
    .right_sliding         (right_sliding),
    .load_pattern          (load_pattern),
    .mask_type             (mask_type),
    .mg_mask               (mg_mask),
    .rp_valid              (rp_valid)
  );

  task automatic chk(input string tag, input logic [0:63] obs, input logic [0:63] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:63] exp_mask();
    logic [0:63] e;
    int wid;
    wid = COLS >> res;
    e = '0;
    for (int i = 0; i < 64; i++) e[i] = (i < wid) ? mdl[i] : 1'b0;
    return e;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    bit nxt[64];
    int wid;
    int pwid;
    bit fb;
    if (rst) begin
      foreach (mdl[i]) mdl[i] = 1'b0;
      m_valid = 1'b0;
      m_prev  = 1'b0;
    end else if (clk_en) begin
      wid = COLS >> res;
      if (load_pattern) begin
        foreach (mdl[i]) mdl[i] = 1'b0;
        if (mask_type == 1'b0) begin
          pwid = (pattern_w == 0) ? 32 : int'(pattern_w);
          for (int i = 0; i < pwid && i < wid; i++) mdl[i] = pattern[i];
        end else begin
          for (int i = 0; i < 32; i++) begin
            mdl[i]      = pattern[i];
            mdl[32 + i] = ~pattern[i];
          end
        end
        m_valid = 1'b1;
      end else begin
        if (mask_type != m_prev) m_valid = 1'b0;
        if (mask_type == 1'b0) begin
          foreach (nxt[i]) nxt[i] = 1'b0;
          for (int i = 0; i < wid; i++) begin
            if (right_sliding) nxt[(i + 1) % wid] = mdl[i];
            else               nxt[(i + wid - 1) % wid] = mdl[i];
          end
          mdl = nxt;
        end else begin
          fb = mdl[0] ^ mdl[1] ^ mdl[3] ^ mdl[4];
          for (int i = 0; i < 63; i++) mdl[i] = mdl[i + 1];
          mdl[63] = fb;
        end
      end
      m_prev = mask_type;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("mask", mg_mask, exp_mask());
    chk("rp_valid", {63'b0, rp_valid}, {63'b0, m_valid});
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic load_slide(input logic [0:31] pat, input logic [4:0] pw, input logic dir);
    pattern       = pat;
    pattern_w     = pw;
    right_sliding = dir;
    mask_type     = 1'b0;
    load_pattern  = 1'b1;
    tick();
    load_pattern  = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    clk_en        = 1'b1;
    res           = 2'b00;
    pattern_w     = 5'd0;
    pattern       = '0;
    right_sliding = 1'b1;
    load_pattern  = 1'b0;
    mask_type     = 1'b0;
    m_valid       = 1'b0;
    m_prev        = 1'b0;
    foreach (mdl[i]) mdl[i] = 1'b0;

    // Reset state
    run(2);
    chk("reset_mask", mg_mask, 64'h0);
    chk("reset_valid", {63'b0, rp_valid}, 64'h0);
    rst = 1'b0;

    // Sliding right with wrap at column 63
    load_slide(32'hF000_0000, 5'd4, 1'b1);
    chk("right_load", mg_mask, 64'hF000_0000_0000_0000);
    chk("right_load_valid", {63'b0, rp_valid}, 64'h1);
    tick();
    chk("right_1", mg_mask, 64'h7800_0000_0000_0000);
    run(59);
    chk("right_60", mg_mask, 64'h0000_0000_0000_000F);
    tick();
    chk("right_61", mg_mask, 64'h8000_0000_0000_0007);

    // Sliding left, then reverse direction mid-run
    load_slide(32'hF000_0000, 5'd4, 1'b0);
    tick();
    chk("left_1", mg_mask, 64'hE000_0000_0000_0001);
    tick();
    chk("left_2", mg_mask, 64'hC000_0000_0000_0003);
    right_sliding = 1'b1;
    tick();
    chk("flip_right", mg_mask, 64'hE000_0000_0000_0001);

    // Half width: wrap from column 31 to 0
    res = 2'b01;
    load_slide(32'hF000_0000, 5'd4, 1'b1);
    run(28);
    chk("half_28", mg_mask, 64'h0000_000F_0000_0000);
    tick();
    chk("half_29", mg_mask, 64'h8000_0007_0000_0000);

    // Eighth width
    res = 2'b11;
    load_slide(32'hF000_0000, 5'd4, 1'b1);
    run(4);
    chk("eighth_4", mg_mask, 64'h0F00_0000_0000_0000);
    tick();
    chk("eighth_5", mg_mask, 64'h8700_0000_0000_0000);

    // Random sliding loads, direction and resolution changes
    repeat (8) begin
      res = 2'($urandom_range(0, 3));
      load_slide($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      repeat (20) begin
        right_sliding = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) res = 2'($urandom_range(0, 3));
        tick();
      end
    end

    // Clock enable low: frozen output, load ignored
    res = 2'b00;
    load_slide(32'h1234_5678, 5'd0, 1'b1);
    run(3);
    saved = mg_mask;
    clk_en = 1'b0;
    load_pattern = 1'b1;
    pattern = 32'hDEAD_BEEF;
    repeat (5) begin
      tick();
      chk("freeze", mg_mask, saved);
    end
    clk_en = 1'b1;
    load_pattern = 1'b0;

    // Random mode
    pattern      = 32'hAAAA_AAAA;
    mask_type    = 1'b1;
    load_pattern = 1'b1;
    tick();
    chk("rand_seed", mg_mask, 64'hAAAA_AAAA_5555_5555);
    load_pattern = 1'b0;
    tick();
    chk("rand_step1", mg_mask, 64'h5555_5554_AAAA_AAAA);
    repeat (1000) begin
      tick();
      total++;
      assert (mg_mask !== 64'h0) else begin
        bad++;
        $error("FAIL rand_nonzero observed=%h expected=nonzero", mg_mask);
      end
    end
    res = 2'b01;
    run(20);
    res = 2'b00;

    // Mode switch without load drops valid until the next load
    mask_type = 1'b0;
    tick();
    chk("switch_valid", {63'b0, rp_valid}, 64'h0);
    run(3);
    mask_type = 1'b1;
    tick();
    chk("switch_back_valid", {63'b0, rp_valid}, 64'h0);
    mask_type = 1'b0;
    load_slide(32'hC000_0000, 5'd2, 1'b1);
    chk("load_switch_valid", {63'b0, rp_valid}, 64'h1);
    chk("load_switch_mask", mg_mask, 64'hC000_0000_0000_0000);

    // Mixed random activity
    repeat (300) begin
      clk_en        = ($urandom_range(0, 3) != 0);
      load_pattern  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) mask_type = ~mask_type;
      right_sliding = 1'($urandom_range(0, 1));
      pattern       = $urandom;
      pattern_w     = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 19) == 0) res = 2'($urandom_range(0, 3));
      rst           = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    clk_en = 1'b1;
    load_pattern = 1'b0;

    // Reset mid-run takes priority over a low clock enable
    load_slide(32'hFFFF_FFFF, 5'd0, 1'b1);
    run(2);
    rst = 1'b1;
    clk_en = 1'b0;
    tick();
    chk("rst_mid_mask", mg_mask, 64'h0);
    chk("rst_mid_valid", {63'b0, rp_valid}, 64'h0);
    rst = 1'b0;
    clk_en = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
